// File: rtl/big_core_pkg.sv
// Shared fabric types for the big_core data-memory fabric controller.
// The tag travels beside these structs because its width is a per-instance parameter.
package big_core_pkg;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } t_opcode;

    localparam int FABRIC_WORD_W = 32;
    localparam int FABRIC_BE_W   = 4;

    typedef struct packed {
        t_opcode                    opcode;
        logic [FABRIC_WORD_W-1:0]   address;
        logic [FABRIC_WORD_W-1:0]   data;
        logic [FABRIC_BE_W-1:0]     byteena;
    } t_fabric_req;

    typedef struct packed {
        logic [FABRIC_WORD_W-1:0]   data;
    } t_fabric_rsp;

endpackage

// File: rtl/big_core_d_mem_fabric_ctrl_fifo.sv
// Generic synchronous FIFO (module fifo) with occupancy count, plus its overflow checker.
// A push while full is accepted only together with a pop.
module fifo_chk (
    input logic clock,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);
    overflow_a: assert property (@(posedge clock) disable iff (rst) !(push && full && !pop));
endmodule

module fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify push/pop against current occupancy.
    always_comb begin
        empty     = (count_r == (PTR_W+1)'(0));
        full      = (count_r == (PTR_W+1)'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write port; contents need no reset since occupancy gates reads.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W)'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    fifo_chk u_chk (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .pop   (do_pop_s),
        .full  (full)
    );

endmodule

// File: rtl/big_core_d_mem_fabric_ctrl.sv
// Credit-based bridge from the fabric request/response port to d_mem port B (2-cycle read latency).
// Define BIG_CORE_FABRIC_WR_ACK_EN to make writes take a credit and return a zero-data response.
module big_core_d_mem_fabric_ctrl
    import big_core_pkg::*;
#(
    parameter int RSP_FIFO_DEPTH = 4,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_opcode,
    input  logic [31:0]          req_address,
    input  logic [31:0]          req_data,
    input  logic [3:0]           req_byteena,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [31:0]          q503_address_b,
    output logic                 q503_wren_b,
    output logic [3:0]           q503_byteena_b,
    output logic [31:0]          q503_data_b,
    input  logic [31:0]          q505_q_b
);
    localparam int FIFO_W = 32 + TAG_WIDTH;
    localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH) + 1;

    t_fabric_req           req_s;
    t_fabric_rsp           push_rsp_s;
    logic                  accept_s;
    logic                  expects_rsp_s;
    logic                  req_ready_s;
    logic [CNT_W:0]        credits_used_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [FIFO_W-1:0]     fifo_head_s;
    logic                  pop_s;
    logic                  addr_lsb_unused_s;

    logic                  q504_valid_r;
    logic                  q504_wr_r;
    logic [TAG_WIDTH-1:0]  q504_tag_r;
    logic                  q505_valid_r;
    logic                  q505_wr_r;
    logic [TAG_WIDTH-1:0]  q505_tag_r;

    assign addr_lsb_unused_s = ^req_address[1:0];

    // Every in-flight response-producing access holds a FIFO slot until it is popped.
    always_comb begin
        credits_used_s = {1'b0, fifo_count_s}
                       + (CNT_W+1)'(q504_valid_r)
                       + (CNT_W+1)'(q505_valid_r);
        if (rst) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = (credits_used_s < (CNT_W+1)'(RSP_FIFO_DEPTH));
        end
    end

    // Accept decode and port-B drive; everything is zero outside an accept.
    always_comb begin
        accept_s = req_valid && req_ready_s;
        req_s    = '0;
        if (accept_s) begin
            req_s.opcode  = t_opcode'(req_opcode);
            req_s.address = {req_address[31:2], 2'b00};
            req_s.data    = req_data;
            req_s.byteena = (t_opcode'(req_opcode) == WR) ? req_byteena : 4'hF;
        end else begin
            req_s = '0;
        end
`ifdef BIG_CORE_FABRIC_WR_ACK_EN
        expects_rsp_s = 1'b1;
`else
        expects_rsp_s = (req_s.opcode == RD);
`endif
    end

    assign req_ready      = req_ready_s;
    assign q503_address_b = req_s.address;
    assign q503_wren_b    = (req_s.opcode == WR);
    assign q503_byteena_b = req_s.byteena;
    assign q503_data_b    = req_s.data;

    // Valid/tag pipeline aligned with the d_mem read latency.
    always_ff @(posedge clock) begin
        if (rst) begin
            q504_valid_r <= 1'b0;
            q504_wr_r    <= 1'b0;
            q504_tag_r   <= '0;
            q505_valid_r <= 1'b0;
            q505_wr_r    <= 1'b0;
            q505_tag_r   <= '0;
        end else begin
            q504_valid_r <= accept_s && expects_rsp_s;
            q504_wr_r    <= (req_s.opcode == WR);
            q504_tag_r   <= req_tag;
            q505_valid_r <= q504_valid_r;
            q505_wr_r    <= q504_wr_r;
            q505_tag_r   <= q504_tag_r;
        end
    end

    // Write acknowledges carry zero data; reads carry the port-B read word.
    always_comb begin
        push_rsp_s = '0;
        if (q505_wr_r) begin
            push_rsp_s.data = 32'h0000_0000;
        end else begin
            push_rsp_s.data = q505_q_b;
        end
    end

    assign pop_s = rsp_valid && rsp_ready;

    fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_rsp_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (q505_valid_r),
        .push_data ({push_rsp_s.data, q505_tag_r}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    // Response port shows the FIFO head, forced to zero when nothing is presented.
    always_comb begin
        rsp_valid = !rst && !fifo_empty_s;
        if (rsp_valid) begin
            rsp_data = fifo_head_s[FIFO_W-1 -: 32];
            rsp_tag  = fifo_head_s[TAG_WIDTH-1:0];
        end else begin
            rsp_data = 32'h0000_0000;
            rsp_tag  = '0;
        end
    end

    logic full_unused_s;
    assign full_unused_s = fifo_full_s;

endmodule

// File: tb/tb_big_core_d_mem_fabric_ctrl.sv
// Directed self-checking bench for big_core_d_mem_fabric_ctrl with a 2-cycle d_mem port-B model.
// Write-response expectations follow BIG_CORE_FABRIC_WR_ACK_EN.
module tb_big_core_d_mem_fabric_ctrl;

    logic        clock = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_opcode;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [3:0]  req_byteena;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [31:0] q503_address_b;
    logic        q503_wren_b;
    logic [3:0]  q503_byteena_b;
    logic [31:0] q503_data_b;
    logic [31:0] q505_q_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];
    logic [9:0]  mem_addr_r;
    logic [31:0] mem_q_r;

    always #5 clock = ~clock;

    big_core_d_mem_fabric_ctrl #(.RSP_FIFO_DEPTH(4), .TAG_WIDTH(8)) dut (
        .clock          (clock),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_byteena    (req_byteena),
        .req_tag        (req_tag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .q503_address_b (q503_address_b),
        .q503_wren_b    (q503_wren_b),
        .q503_byteena_b (q503_byteena_b),
        .q503_data_b    (q503_data_b),
        .q505_q_b       (q505_q_b)
    );

    // d_mem port B: byte-enabled write at issue, read data two cycles after issue.
    always @(posedge clock) begin
        if (q503_wren_b) begin
            for (int b = 0; b < 4; b++) begin
                if (q503_byteena_b[b]) mem[q503_address_b[11:2]][8*b +: 8] <= q503_data_b[8*b +: 8];
            end
        end
        mem_addr_r <= q503_address_b[11:2];
        mem_q_r    <= mem[mem_addr_r];
    end
    assign q505_q_b = mem_q_r;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_opcode  = 1'b0;
        req_address = 32'h0;
        req_data    = 32'h0;
        req_byteena = 4'h0;
        req_tag     = 8'h0;
    endtask

    task automatic drive_read(input logic [31:0] addr, input logic [7:0] tag);
        req_valid   = 1'b1;
        req_opcode  = 1'b0;
        req_address = addr;
        req_data    = 32'h0;
        req_byteena = 4'h0;
        req_tag     = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b0;
        drive_read(32'h0000_0123, 8'hEE);
        req_opcode = 1'b1;
        req_data = 32'hFFFF_FFFF;
        req_byteena = 4'hF;
        step();
        step();
        total++;
        if ({req_ready, rsp_valid, rsp_data, rsp_tag} !== 42'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%0b valid=%0b data=%h tag=%h, want all 0", req_ready, rsp_valid, rsp_data, rsp_tag);
        end
        total++;
        if ({q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b} !== 69'h0) begin
            bad++;
            $display("FAIL reset_q503: got addr=%h wren=%0b be=%h data=%h, want 0", q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b);
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after: got %0b want 1", req_ready);
        end
        step();
    endtask

    task automatic test_single_read();
        rsp_ready = 1'b0;
        drive_read(32'h0000_0103, 8'h5A);
        #1;
        total++;
        if ({req_ready, q503_address_b, q503_wren_b, q503_byteena_b} !== {1'b1, 32'h0000_0100, 1'b0, 4'hF}) begin
            bad++;
            $display("FAIL single_issue: got ready=%0b addr=%h wren=%0b be=%h, want 1 00000100 0 f", req_ready, q503_address_b, q503_wren_b, q503_byteena_b);
        end
        step();
        idle_inputs();
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_early_T+%0d: got rsp_valid=%0b want 0", c, rsp_valid);
            end
            step();
        end
        for (int c = 3; c <= 4; c++) begin
            total++;
            if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'hDEAD_BEEF, 8'h5A}) begin
                bad++;
                $display("FAIL single_rsp_T+%0d: got v=%0b data=%h tag=%h, want 1 deadbeef 5a", c, rsp_valid, rsp_data, rsp_tag);
            end
            if (c == 3) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_popped: got rsp_valid=%0b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_read(32'h0000_0400 + 32'(4 * i), 8'(i));
            #1;
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready_%0d: got %0b want 1", i, req_ready);
            end
            step();
        end
        drive_read(32'h0000_0414, 8'h05);
        #1;
        total++;
        if ({req_ready, q503_address_b} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL b2b_blocked: got ready=%0b addr=%h, want 0 00000000", req_ready, q503_address_b);
        end
        step();
        idle_inputs();
        step();
        step();
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_full_ready: got %0b want 0", req_ready);
        end
        rsp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++;
            if ({rsp_valid, rsp_tag, rsp_data} !== {1'b1, 8'(i), 32'h5A5A_0000 | 32'(i)}) begin
                bad++;
                $display("FAIL b2b_rsp_%0d: got v=%0b tag=%h data=%h, want 1 %h %h", i, rsp_valid, rsp_tag, rsp_data, 8'(i), 32'h5A5A_0000 | 32'(i));
            end
            step();
        end
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained: got rsp_valid=%0b want 0", rsp_valid);
        end
    endtask

    task automatic test_full_stream();
        logic [7:0] next_tag;
        logic [7:0] exp_tag;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_read(32'h0000_0400 + 32'(4 * (8'h21 + i)), 8'(8'h21 + i));
            step();
        end
        idle_inputs();
        step();
        step();
        step();
        next_tag = 8'h10;
        for (int c = 0; c < 15; c++) begin
            if (c < 12) drive_read(32'h0000_0400 + {22'h0, next_tag, 2'b00}, next_tag);
            else idle_inputs();
            rsp_ready = 1'b1;
            #1;
            exp_tag = (c < 4) ? 8'(8'h21 + c) : 8'(8'h10 + c - 4);
            if (c < 12) begin
                total++;
                if (req_ready !== (c != 0)) begin
                    bad++;
                    $display("FAIL stream_ready_c%0d: got %0b want %0b", c, req_ready, (c != 0));
                end
            end
            total++;
            if ({rsp_valid, rsp_tag, rsp_data} !== {1'b1, exp_tag, 32'h5A5A_0000 | {24'h0, exp_tag}}) begin
                bad++;
                $display("FAIL stream_rsp_c%0d: got v=%0b tag=%h data=%h, want 1 %h %h", c, rsp_valid, rsp_tag, rsp_data, exp_tag, 32'h5A5A_0000 | {24'h0, exp_tag});
            end
            if (req_valid && req_ready) next_tag = next_tag + 8'h01;
            step();
        end
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_drained: got rsp_valid=%0b want 0", rsp_valid);
        end
    endtask

    task automatic test_write();
        rsp_ready = 1'b0;
        req_valid   = 1'b1;
        req_opcode  = 1'b1;
        req_address = 32'h0000_0200;
        req_data    = 32'h1234_5678;
        req_byteena = 4'b0011;
        req_tag     = 8'h77;
        #1;
        total++;
        if ({req_ready, q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b} !== {1'b1, 32'h0000_0200, 1'b1, 4'b0011, 32'h1234_5678}) begin
            bad++;
            $display("FAIL write_issue: got rdy=%0b addr=%h wren=%0b be=%b data=%h", req_ready, q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b);
        end
        step();
        idle_inputs();
        step();
        step();
        total++;
`ifdef BIG_CORE_FABRIC_WR_ACK_EN
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'h0, 8'h77}) begin
            bad++;
            $display("FAIL write_ack: got v=%0b data=%h tag=%h, want 1 00000000 77", rsp_valid, rsp_data, rsp_tag);
        end
`else
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_no_ack: got rsp_valid=%0b want 0", rsp_valid);
        end
`endif
        rsp_ready = 1'b1;
        step();
        drive_read(32'h0000_0200, 8'h78);
        step();
        idle_inputs();
        step();
        step();
        total++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'hAAAA_5678, 8'h78}) begin
            bad++;
            $display("FAIL write_readback: got v=%0b data=%h tag=%h, want 1 aaaa5678 78", rsp_valid, rsp_data, rsp_tag);
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        drive_read(32'h0000_0100, 8'h33);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_accept: got ready=%0b want 1", req_ready);
        end
        step();
        rst = 1'b1;
        drive_read(32'h0000_0404, 8'h34);
        #1;
        total++;
        if ({req_ready, q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b} !== 70'h0) begin
            bad++;
            $display("FAIL midrst_q503: got rdy=%0b addr=%h wren=%0b be=%h, want 0", req_ready, q503_address_b, q503_wren_b, q503_byteena_b);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready_after: got %0b want 1", req_ready);
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL midrst_no_rsp_c%0d: got rsp_valid=%0b want 0", c, rsp_valid);
            end
            step();
        end
    endtask

    task automatic test_idle();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req_valid   = 1'b0;
            req_opcode  = 1'b1;
            req_address = $urandom;
            req_data    = $urandom;
            req_byteena = 4'hF;
            req_tag     = 8'($urandom);
            #1;
            total++;
            if ({q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b, rsp_valid} !== 70'h0) begin
                bad++;
                $display("FAIL idle_c%0d: got addr=%h wren=%0b be=%h data=%h rsp_valid=%0b, want 0", c, q503_address_b, q503_wren_b, q503_byteena_b, q503_data_b, rsp_valid);
            end
            step();
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int t = 0; t < 256; t++) mem[256 + t] = 32'h5A5A_0000 | 32'(t);
        mem[10'h040] = 32'hDEAD_BEEF;
        mem[10'h080] = 32'hAAAA_BBBB;
        rst = 1'b1;
        rsp_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_full_stream();
        test_write();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/big_core_d_mem_fabric_ctrl.md
BIG_CORE_D_MEM_FABRIC_CTRL -- requirements
Module: big_core_d_mem_fabric_ctrl

Interface
REQ-001 SHALL have parameter RSP_FIFO_DEPTH, default 4, meaning response FIFO entries and outstanding credit limit (power of 2, >=2).
REQ-002 SHALL have parameter TAG_WIDTH, default 8, meaning width of the request/response tag.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports are named clock and rst.
REQ-004 SHALL have ports:
- clock, input, 1: clock.
- rst, input, 1: sync active-high reset.
- req_valid, input, 1: fabric request valid.
- req_ready, output, 1: request accepted when high with req_valid.
- req_opcode, input, 1: 0 = read, 1 = write.
- req_address, input, 32: byte address; bits [1:0] are ignored, access is word-aligned.
- req_data, input, 32: write data.
- req_byteena, input, 4: write byte enables.
- req_tag, input, TAG_WIDTH: requester tag.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response consumed when high with rsp_valid.
- rsp_data, output, 32: read data.
- rsp_tag, output, TAG_WIDTH: tag of the originating request.
- q503_address_b, output, 32: d_mem port B address.
- q503_wren_b, output, 1: d_mem port B write enable.
- q503_byteena_b, output, 4: d_mem port B byte enables.
- q503_data_b, output, 32: d_mem port B write data.
- q505_q_b, input, 32: d_mem port B read data, valid 2 cycles after the q503 issue.

Function
REQ-005 SHALL treat a request as accepted in cycle T when req_valid && req_ready (cycle T = q503).
REQ-006 SHALL drive port B combinationally in the accept cycle: address = {req_address[31:2],2'b00}, wren = req_opcode, byteena = write ? req_byteena : 4'hF, data = req_data.
REQ-007 SHALL drive all q503 outputs to 0 in any cycle without an accept.
REQ-008 SHALL carry a 2-stage valid+tag pipeline (q504, q505) for every accept that expects a response.
REQ-009 SHALL push {q505_q_b, tag} into the response FIFO in cycle T+2 for an accepted read.
REQ-010 SHALL present the FIFO head on rsp_valid/rsp_data/rsp_tag; the earliest rsp_valid is cycle T+3, and responses are returned in accept order.
REQ-011 SHALL compute credits_used = FIFO occupancy + valid pipeline stages, and drive req_ready = (credits_used < RSP_FIFO_DEPTH); req_ready SHALL NOT depend on req_valid or req_opcode.
REQ-012 SHALL count a pop in the same cycle as a freed credit only from the next cycle (req_ready is registered-state based, with no same-cycle pop bypass).
REQ-013 SHALL accept a simultaneous push and pop on a full FIFO; occupancy stays constant and data is not lost.
REQ-014 SHALL hold rsp_data and rsp_tag stable while rsp_valid && !rsp_ready.
REQ-015 SHALL never overflow the FIFO; an overflow condition is an assertion failure.
REQ-016 SHALL sustain one accept per cycle while credits remain.

Reset
REQ-017 SHALL clear the pipeline valids and the FIFO on rst; outputs SHALL read rsp_valid = 0, rsp_data = 0, rsp_tag = 0, req_ready = 0 during rst, and req_ready = 1 in the first cycle after rst.
REQ-018 SHALL discard in-flight reads on a mid-operation rst, so no response is ever produced for them.
REQ-019 SHALL keep the q503 outputs at 0 while rst is high, regardless of req_valid.

Configuration
REQ-020 SHALL, with macro BIG_CORE_FABRIC_WR_ACK_EN defined, treat writes like reads for credit, pipeline and FIFO purposes and return a response with rsp_data = 0 and the request tag.
REQ-021 SHALL, without BIG_CORE_FABRIC_WR_ACK_EN, make writes consume no credit and produce no response.

Structure
REQ-022 SHALL take t_fabric_req, t_fabric_rsp and the opcode enum (RD = 0, WR = 1) from big_core_pkg.
REQ-023 SHALL instantiate one sub-module, fifo (the generic sync FIFO), parameterised with depth RSP_FIFO_DEPTH and width 32 + TAG_WIDTH.

Verification
REQ-024 Single read: preload word 0x100 = 0xDEADBEEF, read addr 0x103 with tag 0x5A at T -> q503_address_b = 0x100, rsp_valid at T+3, data 0xDEADBEEF, tag 0x5A.
REQ-025 Back-to-back: 4 reads with tags 1..4 and rsp_ready = 0 -> req_ready = 0 from the cycle after the 4th accept; 4 responses returned in order once rsp_ready = 1.
REQ-026 Full + simultaneous: FIFO full with rsp_ready = 1 and a continuous read stream -> one response per cycle, no loss; req_ready reflects the prior-cycle pop.
REQ-027 Write: write 0x12345678 with byteena 4'b0011 to 0x200 -> q503_wren_b = 1, byteena 0011; a later read returns 0x????5678 (upper bytes unchanged); write response present only if BIG_CORE_FABRIC_WR_ACK_EN.
REQ-028 Reset mid-op: rst asserted at T+1 after a read accept -> no rsp_valid ever appears, and req_ready = 1 after rst.
REQ-029 Idle: no req_valid for 10 cycles -> all q503 outputs 0 and rsp_valid = 0.
